// File: rtl/output_router_if.sv
// Bundle between the top-level sequencer / PE return lanes and the output router,
// including the output SRAM write port and the router's status outputs.
interface output_router_if #(
   parameter int unsigned SRAM_DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned ROUTER_COUNT    = 4,
   parameter int unsigned DATA_WIDTH      = 8
);
   logic                               i_en;
   logic                               i_reg_clear;
   logic [ADDR_WIDTH-1:0]              i_start_addr;
   logic [ADDR_WIDTH-1:0]              i_addr_end;
   logic [ROUTER_COUNT*DATA_WIDTH-1:0] i_data;
   logic [ROUTER_COUNT-1:0]            i_data_valid;
   logic                               i_flush;
   logic                               o_ready;
   logic                               o_sram_write_en;
   logic [ADDR_WIDTH-1:0]              o_sram_write_addr;
   logic [SRAM_DATA_WIDTH-1:0]         o_sram_data;
   logic                               o_done;
   logic                               o_overflow;

   modport master (
      output i_en, i_reg_clear, i_start_addr, i_addr_end, i_data, i_data_valid, i_flush,
      input  o_ready, o_sram_write_en, o_sram_write_addr, o_sram_data, o_done, o_overflow
   );

   modport slave (
      input  i_en, i_reg_clear, i_start_addr, i_addr_end, i_data, i_data_valid, i_flush,
      output o_ready, o_sram_write_en, o_sram_write_addr, o_sram_data, o_done, o_overflow
   );
endinterface

// File: rtl/output_router.sv
// Output router: compacts valid result lanes, packs them into SRAM words, writes them sequentially.
// Optional OUTPUT_ROUTER_RELU_EN: clamp negative (signed) lane values to zero before packing.
module output_router #(
   parameter int unsigned SRAM_DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned ROUTER_COUNT    = 4,
   parameter int unsigned DATA_WIDTH      = 8
) (
   input logic          i_clk,
   input logic          i_nrst,
   output_router_if.slave bus
);
   localparam int unsigned W  = SRAM_DATA_WIDTH / DATA_WIDTH;
   localparam int unsigned FW = $clog2(2 * W);
   localparam int unsigned AW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                     state;
   logic [FW-1:0]              fill;
   logic [DATA_WIDTH-1:0]      hold [W];
   logic [AW-1:0]              addr;
   logic [ADDR_WIDTH-1:0]      addr_end;
   logic                       overflow;
   logic                       wr_en;
   logic [ADDR_WIDTH-1:0]      wr_addr;
   logic [SRAM_DATA_WIDTH-1:0] wr_data;
   logic                       done;

   logic [DATA_WIDTH-1:0]      merged [2*W];
   logic [FW-1:0]              new_fill;
   logic [ROUTER_COUNT-1:0]    take;
   logic                       wr_req;
   logic                       in_range;
   logic [SRAM_DATA_WIDTH-1:0] wr_word;

   function automatic logic [DATA_WIDTH-1:0] lane_val(input logic [DATA_WIDTH-1:0] v);
`ifdef OUTPUT_ROUTER_RELU_EN
      return v[DATA_WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   // Held bytes followed by this cycle's valid lanes, compacted in lane order.
   always_comb begin
      take     = (state == RUN) ? bus.i_data_valid : '0;
      new_fill = fill;
      wr_word  = '0;
      for (int i = 0; i < int'(2 * W); i++) merged[i] = '0;
      for (int i = 0; i < int'(W); i++)
         if (FW'(i) < fill) merged[i] = hold[i];
      for (int r = 0; r < int'(ROUTER_COUNT); r++) begin
         if (take[r]) begin
            merged[new_fill] = lane_val(bus.i_data[r*DATA_WIDTH +: DATA_WIDTH]);
            new_fill         = new_fill + FW'(1);
         end
      end
      for (int k = 0; k < int'(W); k++) wr_word[k*DATA_WIDTH +: DATA_WIDTH] = merged[k];
      wr_req   = ((state == RUN) && (new_fill >= FW'(W))) ||
                 ((state == FLUSH) && (new_fill != '0));
      in_range = (addr <= {1'b0, addr_end});
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state    <= IDLE;
         fill     <= '0;
         for (int i = 0; i < int'(W); i++) hold[i] <= '0;
         addr     <= '0;
         addr_end <= '0;
         overflow <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
      end else if (bus.i_reg_clear) begin
         state    <= IDLE;
         fill     <= '0;
         for (int i = 0; i < int'(W); i++) hold[i] <= '0;
         addr     <= '0;
         addr_end <= '0;
         overflow <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         // Out-of-range writes are dropped; the address saturates once past the top.
         if (wr_req) begin
            if (in_range) begin
               wr_en   <= 1'b1;
               wr_addr <= addr[ADDR_WIDTH-1:0];
               wr_data <= wr_word;
            end else begin
               overflow <= 1'b1;
            end
            if (!addr[ADDR_WIDTH]) addr <= addr + AW'(1);
         end
         unique case (state)
            IDLE: begin
               if (bus.i_en) begin
                  state    <= RUN;
                  addr     <= {1'b0, bus.i_start_addr};
                  addr_end <= bus.i_addr_end;
                  overflow <= 1'b0;
                  fill     <= '0;
               end
            end
            RUN: begin
               if (new_fill >= FW'(W)) begin
                  for (int i = 0; i < int'(W); i++) hold[i] <= merged[i + int'(W)];
                  fill <= new_fill - FW'(W);
               end else begin
                  for (int i = 0; i < int'(W); i++) hold[i] <= merged[i];
                  fill <= new_fill;
               end
               if (bus.i_flush) state <= FLUSH;
            end
            FLUSH: begin
               fill  <= '0;
               for (int i = 0; i < int'(W); i++) hold[i] <= '0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_ready           = (state == RUN);
   assign bus.o_sram_write_en   = wr_en;
   assign bus.o_sram_write_addr = wr_addr;
   assign bus.o_sram_data       = wr_data;
   assign bus.o_done            = done;
   assign bus.o_overflow        = overflow;
endmodule
